// File: rtl/scratch_ram.sv
// Block-RAM responder for the 16-bit four-phase req/ack memory port, with programmable
// wait states, byte-lane writes and a saturating out-of-range access counter.
module scratch_ram #(
  parameter int unsigned DEPTH_LOG2  = 8,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned ADR_W       = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ADR_W-1:0] a_adr,
  input  logic             a_req,
  output logic             a_ack,
  input  logic             a_write,
  input  logic [1:0]       a_sel,
  output logic [15:0]      a_rdata,
  input  logic [15:0]      a_wdata,
  output logic [7:0]       oob_count
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [ADR_W-1:0] adr_q;
  logic             write_q;
  logic [1:0]       sel_q;
  logic [15:0]      wdata_q;
  logic             ack_q, ack_d;
  logic [15:0]      rdata_q, rdata_d;
  logic [7:0]       oob_q, oob_d;

  logic [15:0]           mem [Depth];
  logic                  accept, commit, in_range, mem_we;
  logic [DEPTH_LOG2-1:0] idx;
  logic [15:0]           lane_mask;

  assign accept    = (state_q == StIdle) && a_req;
  assign commit    = (state_q == StAccess) && (cnt_q == 4'(WAIT_STATES));
  assign in_range  = (adr_q >> DEPTH_LOG2) == '0;
  assign idx       = adr_q[DEPTH_LOG2-1:0];
  assign lane_mask = {{8{sel_q[1]}}, {8{sel_q[0]}}};
  // A reset landing on the commit edge discards the pending write.
  assign mem_we    = commit && write_q && in_range && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
      oob_q   <= '0;
      adr_q   <= '0;
      write_q <= 1'b0;
      sel_q   <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      oob_q   <= oob_d;
      if (accept) begin
        adr_q   <= a_adr;
        write_q <= a_write;
        sel_q   <= a_sel;
        wdata_q <= a_wdata;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (a_req) begin
          state_d = StAccess;
          cnt_d   = '0;
        end
      end
      StAccess: begin
        if (commit) state_d = StDone;
        else        cnt_d   = cnt_q + 4'd1;
      end
      StDone: begin
        if (!a_req) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ack_d   = 1'b0;
    rdata_d = rdata_q;
    oob_d   = oob_q;
    unique case (state_q)
      StAccess: ack_d = commit;
      StDone:   ack_d = a_req;
      default:  ack_d = 1'b0;
    endcase
    if (commit && !write_q) begin
      rdata_d = in_range ? (mem[idx] & lane_mask) : 16'hFFFF;
    end
    if (commit && !in_range && (oob_q != 8'hFF)) begin
      oob_d = oob_q + 8'd1;
    end
  end

  // Storage has no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      if (sel_q[0]) mem[idx][7:0]  <= wdata_q[7:0];
      if (sel_q[1]) mem[idx][15:8] <= wdata_q[15:8];
    end
  end

  assign a_ack     = ack_q;
  assign a_rdata   = rdata_q;
  assign oob_count = oob_q;

endmodule
